// File: rtl/znd_rcv.sv
// znd_rcv - echo-receive sequencer.
//
// A fire strobe opens a receive window on the fired channel. The block waits
// rcv_delay blanking cycles, then captures rcv_len groups of (dec+1) rectified
// ADC samples. It reduces each group to its peak and streams the peaks out on a
// valid/ready port. It also records the index of the first peak >= thr
// (time of flight). msync_n aborts and re-arms the block.
//
// Ports:
//   clk20, res_n            clock, synchronous active-low reset
//   msync_n                 master sync (active-low), aborts to IDLE
//   fire_n, fire_ch         one-cycle fire strobe and its channel
//   adc_data                rectified sample, one per clk20
//   rcv_delay, rcv_len, dec, thr   window configuration (change only in IDLE)
//   out_valid/out_ready, out_data, out_ch, out_idx, out_last   peak stream
//   tof, tof_vld            time-of-flight result
//   busy, ovf, miss         status: active, dropped word, fire while busy
module znd_rcv #(
    parameter int ADC_W = 10,
    parameter int DLY_W = 16,
    parameter int LEN_W = 10
) (
    input  logic             clk20,
    input  logic             res_n,
    input  logic             msync_n,
    input  logic             fire_n,
    input  logic [1:0]       fire_ch,
    input  logic [ADC_W-1:0] adc_data,
    input  logic [DLY_W-1:0] rcv_delay,
    input  logic [LEN_W-1:0] rcv_len,
    input  logic [3:0]       dec,
    input  logic [ADC_W-1:0] thr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ADC_W-1:0] out_data,
    output logic [1:0]       out_ch,
    output logic [LEN_W-1:0] out_idx,
    output logic             out_last,
    output logic [LEN_W-1:0] tof,
    output logic             tof_vld,
    output logic             busy,
    output logic             ovf,
    output logic             miss
);

    typedef enum logic [1:0] {IDLE, BLANK, ACQ} state_t;

    state_t           state, state_nx;
    logic [DLY_W-1:0] dly_cnt;
    logic [3:0]       smp_cnt;
    logic [LEN_W-1:0] idx;
    logic [ADC_W-1:0] peak;
    logic [1:0]       cur_ch;

    logic             accept;
    logic             grp_close;
    logic             win_end;
    logic             can_load;
    logic [ADC_W-1:0] pk_nx;

    assign busy      = (state != IDLE);
    assign accept    = (state == IDLE) && !fire_n && (rcv_len != '0);
    assign grp_close = (state == ACQ) && (smp_cnt == dec);
    assign win_end   = grp_close && (idx == rcv_len - 1'b1);
    // Output register is free if empty or being drained on this same edge.
    assign can_load  = !out_valid || out_ready;
    // First sample of a group loads the peak; later ones take the max.
    assign pk_nx     = ((smp_cnt == '0) || (adc_data > peak)) ? adc_data : peak;

    always_ff @(posedge clk20) begin
        if (!res_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = (rcv_delay != '0) ? BLANK : ACQ;
            BLANK:   if (dly_cnt == rcv_delay - 1'b1) state_nx = ACQ;
            ACQ:     if (win_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (!msync_n) state_nx = IDLE;
    end

    always_ff @(posedge clk20) begin
        if (!res_n) begin
            dly_cnt   <= '0;
            smp_cnt   <= '0;
            idx       <= '0;
            peak      <= '0;
            cur_ch    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            tof       <= '0;
            tof_vld   <= 1'b0;
            ovf       <= 1'b0;
            miss      <= 1'b0;
        end else if (!msync_n) begin
            dly_cnt   <= '0;
            smp_cnt   <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            tof_vld   <= 1'b0;
            ovf       <= 1'b0;
            miss      <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            // Includes the edge where ACQ ends: still busy on that edge.
            if (!fire_n && busy) miss <= 1'b1;
            case (state)
                IDLE: if (accept) begin
                    cur_ch  <= fire_ch;
                    tof_vld <= 1'b0;
                    dly_cnt <= '0;
                    smp_cnt <= '0;
                    idx     <= '0;
                end
                BLANK: dly_cnt <= dly_cnt + 1'b1;
                ACQ: begin
                    peak <= pk_nx;
                    if (grp_close) begin
                        smp_cnt <= '0;
                        idx     <= idx + 1'b1;
                        if (can_load) begin
                            out_valid <= 1'b1;
                            out_data  <= pk_nx;
                            out_ch    <= cur_ch;
                            out_idx   <= idx;
                            out_last  <= win_end;
                        end else begin
                            ovf <= 1'b1;
                        end
                        // tof_vld is cleared at fire, so it marks "already found".
                        if (!tof_vld && (pk_nx >= thr)) begin
                            tof     <= idx;
                            tof_vld <= 1'b1;
                        end
                    end else begin
                        smp_cnt <= smp_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
